// File: rtl/tag_rx_ctrl_mr.sv
// Multi-round tag RX controller. Waits for a preamble peak, emits a +/- sync
// pattern, hands the baseband path to tag_rx, re-syncs for a configured number
// of localisation rounds, then applies a receive timeout and a post-burst
// holdoff. The IQ output stream is muxed and delayed by two register stages.
module tag_rx_ctrl_mr #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TO_WIDTH       = 32,
  parameter int unsigned RND_WIDTH      = 8,
  parameter int unsigned GPIO_REG_WIDTH = 12,
  parameter int          SYNC_AMP       = 16384
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run_rx,
  input  logic [CNT_WIDTH-1:0]      cfg_nsyncp,
  input  logic [CNT_WIDTH-1:0]      cfg_nsyncn,
  input  logic [RND_WIDTH-1:0]      cfg_nrounds,
  input  logic [TO_WIDTH-1:0]       cfg_timeout,
  input  logic [TO_WIDTH-1:0]       cfg_holdoff,
  input  logic                      peak_tvalid,
  input  logic                      peak_stb,
  input  logic                      rx_sync_ready,
  input  logic [DATA_WIDTH-1:0]     irx_bb,
  input  logic [DATA_WIDTH-1:0]     qrx_bb,
  output logic                      rx_srst,
  output logic                      rx_valid,
  output logic [DATA_WIDTH-1:0]     irx_out,
  output logic [DATA_WIDTH-1:0]     qrx_out,
  output logic [1:0]                rx_state,
  output logic [CNT_WIDTH:0]        sync_count,
  output logic [RND_WIDTH-1:0]      round_count,
  output logic                      timeout_flag,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr
);

  localparam int unsigned SyncW = CNT_WIDTH + 1;
  localparam int unsigned RndW  = RND_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] AmpPos = DATA_WIDTH'(SYNC_AMP);
  localparam logic [DATA_WIDTH-1:0] AmpNeg = DATA_WIDTH'(-SYNC_AMP);

  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StLocSync = 2'd1,
    StLocRx   = 2'd2,
    StHoldoff = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SyncW-1:0]       sync_cnt_q, sync_cnt_d;
  logic [RND_WIDTH-1:0]   round_q, round_d;
  logic [TO_WIDTH-1:0]    tmr_q, tmr_d;
  logic                   to_flag_q, to_flag_d;
  logic                   valid_q, valid_d;
  logic                   srst_q, srst_d;
  logic                   pk_q, pk_d;

  // Shadowed config, frozen for the duration of a burst
  logic [CNT_WIDTH-1:0]   nsyncp_q, nsyncp_d;
  logic [CNT_WIDTH-1:0]   nsyncn_q, nsyncn_d;
  logic [RND_WIDTH-1:0]   nrounds_q, nrounds_d;
  logic [TO_WIDTH-1:0]    timeout_q, timeout_d;
  logic [TO_WIDTH-1:0]    holdoff_q, holdoff_d;

  logic [DATA_WIDTH-1:0]  i_mux, q_mux;
  logic [DATA_WIDTH-1:0]  i_s1_q, q_s1_q, i_s2_q, q_s2_q;

  logic                   clear;
  logic [SyncW-1:0]       sync_raw, sync_total, sync_last;
  logic [RndW-1:0]        rounds_eff, round_inc;
  logic                   timeout_hit, holdoff_done;

  assign clear = !reset || !run_rx;

  // Derived limits from the shadowed config
  always_comb begin
    sync_raw     = {1'b0, nsyncp_q} + {1'b0, nsyncn_q};
    sync_total   = (sync_raw == '0) ? SyncW'(1) : sync_raw;
    sync_last    = sync_total - SyncW'(1);
    rounds_eff   = (nrounds_q == '0) ? RndW'(1) : {1'b0, nrounds_q};
    round_inc    = {1'b0, round_q} + RndW'(1);
    timeout_hit  = (timeout_q != '0) && (tmr_q == timeout_q - TO_WIDTH'(1));
    holdoff_done = (holdoff_q == '0) || (tmr_q >= holdoff_q - TO_WIDTH'(1));
  end

  // Next-state logic for the burst sequencer
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    round_d    = round_q;
    tmr_d      = tmr_q;
    to_flag_d  = to_flag_q;
    valid_d    = valid_q;
    srst_d     = srst_q;
    pk_d       = peak_tvalid & peak_stb;
    nsyncp_d   = nsyncp_q;
    nsyncn_d   = nsyncn_q;
    nrounds_d  = nrounds_q;
    timeout_d  = timeout_q;
    holdoff_d  = holdoff_q;

    case (state_q)
      StInit: begin
        if (peak_tvalid && peak_stb) begin
          state_d    = StLocSync;
          sync_cnt_d = '0;
          round_d    = '0;
          valid_d    = 1'b1;
          nsyncp_d   = cfg_nsyncp;
          nsyncn_d   = cfg_nsyncn;
          nrounds_d  = cfg_nrounds;
          timeout_d  = cfg_timeout;
          holdoff_d  = cfg_holdoff;
        end else if (peak_tvalid) begin
          valid_d = 1'b0;
        end
      end
      StLocSync: begin
        if (sync_cnt_q < sync_last) begin
          sync_cnt_d = sync_cnt_q + SyncW'(1);
          srst_d     = 1'b1;
        end else begin
          srst_d  = 1'b0;
          state_d = StLocRx;
          tmr_d   = '0;
        end
      end
      StLocRx: begin
        tmr_d = tmr_q + TO_WIDTH'(1);
        // A ready in the same cycle as the timeout takes priority
        if (rx_sync_ready && peak_tvalid) begin
          round_d = round_inc[RND_WIDTH-1:0];
          if (round_inc < rounds_eff) begin
            state_d    = StLocSync;
            sync_cnt_d = '0;
          end else begin
            state_d = StHoldoff;
            tmr_d   = '0;
          end
        end else if (timeout_hit) begin
          to_flag_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = StInit;
        end
      end
      StHoldoff: begin
        tmr_d = tmr_q + TO_WIDTH'(1);
        if (holdoff_done) begin
          state_d = StInit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Sync pattern during LOC_SYNC, baseband passthrough otherwise
  always_comb begin
    i_mux = irx_bb;
    q_mux = qrx_bb;
    if (state_q == StLocSync) begin
      i_mux = (sync_cnt_q < {1'b0, nsyncp_q}) ? AmpPos : AmpNeg;
      q_mux = '0;
    end
  end

  // State, counters, shadow config and the two-stage IQ pipeline
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StInit;
      sync_cnt_q <= '0;
      round_q    <= '0;
      tmr_q      <= '0;
      to_flag_q  <= 1'b0;
      valid_q    <= 1'b0;
      srst_q     <= 1'b0;
      pk_q       <= 1'b0;
      nsyncp_q   <= '0;
      nsyncn_q   <= '0;
      nrounds_q  <= '0;
      timeout_q  <= '0;
      holdoff_q  <= '0;
      i_s1_q     <= '0;
      q_s1_q     <= '0;
      i_s2_q     <= '0;
      q_s2_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      round_q    <= round_d;
      tmr_q      <= tmr_d;
      to_flag_q  <= to_flag_d;
      valid_q    <= valid_d;
      srst_q     <= srst_d;
      pk_q       <= pk_d;
      nsyncp_q   <= nsyncp_d;
      nsyncn_q   <= nsyncn_d;
      nrounds_q  <= nrounds_d;
      timeout_q  <= timeout_d;
      holdoff_q  <= holdoff_d;
      i_s1_q     <= i_mux;
      q_s1_q     <= q_mux;
      i_s2_q     <= i_s1_q;
      q_s2_q     <= q_s1_q;
    end
  end

  assign rx_srst      = srst_q;
  assign rx_valid     = valid_q;
  assign irx_out      = i_s2_q;
  assign qrx_out      = q_s2_q;
  assign rx_state     = state_q;
  assign sync_count   = sync_cnt_q;
  assign round_count  = round_q;
  assign timeout_flag = to_flag_q;
  assign fp_gpio_out  = GPIO_REG_WIDTH'({(state_q == StLocSync), pk_q});
  assign fp_gpio_ddr  = GPIO_REG_WIDTH'(3);

endmodule

// File: tb/tb_tag_rx_ctrl_mr.sv
// Directed bench for tag_rx_ctrl_mr. Stimulus pushes cycle-stamped expected
// values into a scoreboard; a monitor on the falling edge pops and compares.
module tb_tag_rx_ctrl_mr;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 32;
  localparam int unsigned RW = 8;
  localparam int unsigned GW = 12;

  localparam logic [31:0] AP = 32'h0000_4000;
  localparam logic [31:0] AN = 32'h0000_C000;

  logic          clk = 1'b0;
  logic          reset, run_rx;
  logic [CW-1:0] cfg_nsyncp, cfg_nsyncn;
  logic [RW-1:0] cfg_nrounds;
  logic [TW-1:0] cfg_timeout, cfg_holdoff;
  logic          peak_tvalid, peak_stb, rx_sync_ready;
  logic [DW-1:0] irx_bb, qrx_bb;
  logic          rx_srst, rx_valid;
  logic [DW-1:0] irx_out, qrx_out;
  logic [1:0]    rx_state;
  logic [CW:0]   sync_count;
  logic [RW-1:0] round_count;
  logic          timeout_flag;
  logic [GW-1:0] fp_gpio_out, fp_gpio_ddr;

  always #5 clk = ~clk;

  tag_rx_ctrl_mr dut (
    .clk          (clk),
    .reset        (reset),
    .run_rx       (run_rx),
    .cfg_nsyncp   (cfg_nsyncp),
    .cfg_nsyncn   (cfg_nsyncn),
    .cfg_nrounds  (cfg_nrounds),
    .cfg_timeout  (cfg_timeout),
    .cfg_holdoff  (cfg_holdoff),
    .peak_tvalid  (peak_tvalid),
    .peak_stb     (peak_stb),
    .rx_sync_ready(rx_sync_ready),
    .irx_bb       (irx_bb),
    .qrx_bb       (qrx_bb),
    .rx_srst      (rx_srst),
    .rx_valid     (rx_valid),
    .irx_out      (irx_out),
    .qrx_out      (qrx_out),
    .rx_state     (rx_state),
    .sync_count   (sync_count),
    .round_count  (round_count),
    .timeout_flag (timeout_flag),
    .fp_gpio_out  (fp_gpio_out),
    .fp_gpio_ddr  (fp_gpio_ddr)
  );

  typedef enum int {
    SelState, SelSrst, SelValid, SelI, SelQ, SelSync, SelRound, SelFlag, SelGpio, SelDdr
  } sel_e;

  typedef struct {
    int          when;
    sel_e        sel;
    logic [31:0] val;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   test_id = 0;
  int   total   = 0;
  int   bad     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sel_name(input sel_e s);
    case (s)
      SelState: return "rx_state";
      SelSrst:  return "rx_srst";
      SelValid: return "rx_valid";
      SelI:     return "irx_out";
      SelQ:     return "qrx_out";
      SelSync:  return "sync_count";
      SelRound: return "round_count";
      SelFlag:  return "timeout_flag";
      SelGpio:  return "fp_gpio_out";
      default:  return "fp_gpio_ddr";
    endcase
  endfunction

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      SelState: return 32'(rx_state);
      SelSrst:  return 32'(rx_srst);
      SelValid: return 32'(rx_valid);
      SelI:     return 32'(irx_out);
      SelQ:     return 32'(qrx_out);
      SelSync:  return 32'(sync_count);
      SelRound: return 32'(round_count);
      SelFlag:  return 32'(timeout_flag);
      SelGpio:  return 32'(fp_gpio_out);
      default:  return 32'(fp_gpio_ddr);
    endcase
  endfunction

  // Expect signal s to equal v after k more rising edges
  task automatic expect_at(input int k, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.when = cyc + k;
    e.sel  = s;
    e.val  = v;
    e.tag  = test_id;
    sb.push_back(e);
  endtask

  // Monitor: compare every due scoreboard entry away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].when <= cyc) begin
          logic [31:0] a;
          a = actual(sb[i].sel);
          total++;
          if (a !== sb[i].val) begin
            bad++;
            $display("FAIL %s (test %0d, cycle %0d): got 'h%0h, want 'h%0h",
                     sel_name(sb[i].sel), sb[i].tag, cyc, a, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peak_pulse();
    peak_tvalid = 1'b1;
    peak_stb    = 1'b1;
    tick(1);
    peak_tvalid = 1'b0;
    peak_stb    = 1'b0;
  endtask

  task automatic ready_pulse();
    rx_sync_ready = 1'b1;
    peak_tvalid   = 1'b1;
    tick(1);
    rx_sync_ready = 1'b0;
    peak_tvalid   = 1'b0;
  endtask

  task automatic set_cfg(input int p, input int n, input int r, input int to, input int ho);
    cfg_nsyncp  = CW'(p);
    cfg_nsyncn  = CW'(n);
    cfg_nrounds = RW'(r);
    cfg_timeout = TW'(to);
    cfg_holdoff = TW'(ho);
  endtask

  initial begin
    reset         = 1'b0;
    run_rx        = 1'b1;
    peak_tvalid   = 1'b0;
    peak_stb      = 1'b0;
    rx_sync_ready = 1'b0;
    irx_bb        = 16'h1234;
    qrx_bb        = 16'h0567;
    set_cfg(4, 4, 1, 0, 0);

    // Reset state
    test_id = 0;
    tick(2);
    expect_at(0, SelState, 0); expect_at(0, SelSrst, 0); expect_at(0, SelValid, 0);
    expect_at(0, SelI, 0);     expect_at(0, SelQ, 0);    expect_at(0, SelGpio, 0);
    expect_at(0, SelFlag, 0);  expect_at(0, SelSync, 0); expect_at(0, SelRound, 0);
    reset = 1'b1;
    tick(1);
    expect_at(0, SelDdr, 3);

    // 4+4 sync, single round, no timeout, no holdoff
    test_id = 1;
    peak_pulse();
    expect_at(0, SelState, 1); expect_at(0, SelSync, 0); expect_at(0, SelSrst, 0);
    expect_at(0, SelValid, 1); expect_at(0, SelGpio, 3);
    expect_at(1, SelGpio, 2);  expect_at(1, SelSrst, 1);
    expect_at(7, SelState, 1); expect_at(7, SelSync, 7); expect_at(7, SelSrst, 1);
    expect_at(8, SelState, 2); expect_at(8, SelSrst, 0);
    expect_at(2, SelI, AP);    expect_at(5, SelI, AP);
    expect_at(6, SelI, AN);    expect_at(9, SelI, AN);
    expect_at(2, SelQ, 0);     expect_at(9, SelQ, 0);
    expect_at(10, SelI, 32'h1234); expect_at(10, SelQ, 32'h0567);
    expect_at(9, SelState, 3); expect_at(9, SelRound, 1);
    expect_at(10, SelState, 0); expect_at(10, SelValid, 1); expect_at(10, SelGpio, 0);
    tick(8);
    ready_pulse();
    tick(2);

    // Three rounds from one peak, holdoff 5, peak ignored in holdoff
    test_id = 2;
    set_cfg(1, 1, 3, 0, 5);
    peak_pulse();
    expect_at(0, SelState, 1);  expect_at(0, SelRound, 0);
    expect_at(2, SelState, 2);
    expect_at(3, SelState, 1);  expect_at(3, SelRound, 1); expect_at(3, SelSync, 0);
    expect_at(5, SelState, 2);
    expect_at(6, SelState, 1);  expect_at(6, SelRound, 2);
    expect_at(9, SelState, 3);  expect_at(9, SelRound, 3);
    expect_at(11, SelState, 3); expect_at(11, SelGpio, 1);
    expect_at(13, SelState, 3);
    expect_at(14, SelState, 0); expect_at(14, SelRound, 3); expect_at(14, SelValid, 1);
    tick(2);
    ready_pulse();
    tick(2);
    ready_pulse();
    tick(2);
    ready_pulse();
    tick(1);
    peak_pulse();
    tick(4);

    // Timeout of 10 cycles with no ready
    test_id = 3;
    set_cfg(1, 0, 1, 10, 0);
    peak_pulse();
    expect_at(0, SelState, 1);
    expect_at(1, SelState, 2);
    expect_at(2, SelI, AP);
    expect_at(10, SelState, 2); expect_at(10, SelFlag, 0);
    expect_at(11, SelState, 0); expect_at(11, SelFlag, 1); expect_at(11, SelValid, 0);
    tick(12);

    // Flag is sticky into the next burst; run_rx low clears everything
    test_id = 4;
    peak_pulse();
    expect_at(0, SelFlag, 1); expect_at(0, SelValid, 1); expect_at(0, SelState, 1);
    expect_at(1, SelState, 2);
    tick(1);
    run_rx = 1'b0;
    tick(1);
    expect_at(0, SelState, 0); expect_at(0, SelFlag, 0);
    expect_at(0, SelValid, 0); expect_at(0, SelSrst, 0);
    run_rx = 1'b1;
    tick(1);

    // Ready and timeout in the same cycle: round counted, no timeout
    test_id = 5;
    set_cfg(1, 0, 2, 3, 0);
    peak_pulse();
    expect_at(1, SelState, 2); expect_at(3, SelState, 2);
    expect_at(4, SelState, 1); expect_at(4, SelRound, 1); expect_at(4, SelFlag, 0);
    expect_at(5, SelState, 2);
    expect_at(6, SelState, 3); expect_at(6, SelRound, 2);
    expect_at(7, SelState, 0); expect_at(7, SelFlag, 0); expect_at(7, SelValid, 1);
    tick(3);
    ready_pulse();
    tick(1);
    ready_pulse();
    tick(2);

    // Reset low mid-sync at sync_count 3
    test_id = 6;
    set_cfg(4, 4, 1, 0, 0);
    peak_pulse();
    expect_at(3, SelSync, 3); expect_at(3, SelSrst, 1); expect_at(3, SelState, 1);
    tick(3);
    reset = 1'b0;
    tick(1);
    expect_at(0, SelState, 0); expect_at(0, SelSrst, 0); expect_at(0, SelSync, 0);
    expect_at(0, SelI, 0);     expect_at(0, SelQ, 0);    expect_at(0, SelValid, 0);
    expect_at(0, SelGpio, 0);
    reset = 1'b1;
    tick(1);

    // Config change mid-burst does not alter the current sync
    test_id = 7;
    set_cfg(2, 2, 1, 0, 0);
    peak_pulse();
    expect_at(3, SelState, 1); expect_at(3, SelSync, 3);
    expect_at(4, SelState, 2);
    expect_at(2, SelI, AP);    expect_at(4, SelI, AN);
    expect_at(5, SelState, 3); expect_at(6, SelState, 0);
    tick(1);
    set_cfg(8, 8, 4, 0, 0);
    tick(3);
    ready_pulse();
    tick(2);

    // Zero-length sync clamps to one negative sample; tvalid without stb drops valid
    test_id = 8;
    set_cfg(0, 0, 1, 0, 0);
    peak_pulse();
    expect_at(0, SelState, 1);
    expect_at(1, SelState, 2);
    expect_at(2, SelI, AN);    expect_at(2, SelQ, 0);   expect_at(2, SelState, 3);
    expect_at(3, SelState, 0); expect_at(3, SelValid, 1);
    expect_at(4, SelState, 0); expect_at(4, SelValid, 0);
    tick(1);
    ready_pulse();
    tick(1);
    peak_tvalid = 1'b1;
    tick(1);
    peak_tvalid = 1'b0;
    tick(2);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
